// File: rtl/lsu_wb.sv
// Load/store unit with write-back port for the RV32I core.
// Takes one memory op at a time from execute. It drives a word-addressed
// req/gnt/rvalid data bus, then for loads writes the extended data to the
// register file.
// Optional feature: define LSU_TIMEOUT_EN to add a bus timeout of BUS_TIMEOUT
// cycles in REQ/WAIT_R and to reject misaligned accesses with err.
module lsu_wb #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  err
);

  if (BUS_TIMEOUT == 0) begin : g_bad_timeout
    $error("lsu_wb: BUS_TIMEOUT must be non-zero");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WB} state_t;

  state_t      state, state_next;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;
  logic [4:0]  op_rd;
  logic        accept, legal, start, timeout_hit, err_next;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ldata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign req_ready = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign wb_we     = (state == WB) && (op_rd != '0);
  assign accept    = req_valid && req_ready;

  // Decode which funct3 values are legal for the requested direction
  always_comb begin
    legal = 1'b0;
    if (req_we) begin
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic misaligned;

  // Flag accesses whose address is not naturally aligned to the access size
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign start = accept && legal && !misaligned;
`else
  assign start = accept && legal;
`endif

  // Store lane placement; loads always read the full word
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << req_addr[1:0];
          wdata_new = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{req_wdata[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = req_wdata;
        end
      endcase
    end
  end

  // Load lane selection and sign/zero extension of the returned word
  always_comb begin
    byte_sel = mem_rdata[{op_off, 3'b000} +: 8];
    half_sel = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_f3)
      3'b000:  ldata = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ldata = {{16{half_sel[15]}}, half_sel};
      3'b100:  ldata = {24'h0, byte_sel};
      3'b101:  ldata = {16'h0, half_sel};
      default: ldata = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  logic [CNT_W-1:0] to_cnt;

  // Cycles spent in the current REQ or WAIT_R visit; cleared on every state change
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      to_cnt <= '0;
    end else if ((state_next != state) || !((state == REQ) || (state == WAIT_R))) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = ((state == REQ) || (state == WAIT_R)) &&
                       (to_cnt == CNT_W'(BUS_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and error pulse generation
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (start) state_next = REQ;
          else       err_next   = 1'b1;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_next = mem_we ? IDLE : WAIT_R;
        end else if (timeout_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_next = WB;
        end else if (timeout_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the accepted op; bus fields then stay stable until the grant
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      op_f3     <= '0;
      op_off    <= '0;
      op_rd     <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      op_f3     <= req_funct3;
      op_off    <= req_addr[1:0];
      op_rd     <= req_rd;
      mem_we    <= req_we;
      mem_be    <= be_new;
      mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      mem_wdata <= wdata_new;
    end
  end

  // Write-back address/data, loaded when read data arrives and held afterwards
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wb_rd   <= '0;
      wb_data <= '0;
    end else if ((state == WAIT_R) && mem_rvalid) begin
      wb_rd   <= op_rd;
      wb_data <= ldata;
    end
  end

  // Error pulse register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      err <= 1'b0;
    end else begin
      err <= err_next;
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// Scoreboard testbench for lsu_wb: stimulus pushes expected bus, write-back
// and error events; responder/monitor processes pop and compare.
module tb_lsu_wb;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [4:0]    req_rd = '0;
  logic          mem_req;
  logic          mem_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          err;

  lsu_wb #(.ADDR_WIDTH(AW), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  bus_t        bus_q[$];
  wb_t         wb_q[$];
  int          err_q[$];
  logic [31:0] rdata_q[$];

  int checks = 0;
  int errors = 0;
  int gnt_mode = 0;    // 0 random, 1 always, 2 never
  int rv_mode = 0;     // 0 random, 1 immediate, 2 withheld
  int rd_pending = 0;  // granted loads still owed read data

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: bus lanes, store data and load result from access size and offset
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata,
                                output bit ok, output logic [3:0] be,
                                output logic [31:0] wdata, output logic [31:0] ldata);
    int unsigned size, off;
    logic [31:0] v, mask;
    be = '0; wdata = '0; ldata = '0;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!ok) return;
    size = 1 << f3[1:0];
    off  = addr % 4;
`ifdef LSU_TIMEOUT_EN
    if ((off % size) != 0) begin
      ok = 1'b0;
      return;
    end
`endif
    off = off - (off % size);
    be  = we ? 4'(((1 << size) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    v = rdata >> (8 * off);
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
    end
    ldata = v;
  endfunction

  // Bus responder: checks granted requests, holds-stability, and returns read data
  initial begin : responder
    bus_t pv, exp;
    bit   pv_ok = 1'b0;
    bit   rv_real = 1'b0;
    int   gwait = 0, rwait = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (pv_ok) begin
          check("hold_addr", mem_addr, pv.addr);
          check("hold_we", {31'b0, mem_we}, {31'b0, pv.we});
          check("hold_be", {28'b0, mem_be}, {28'b0, pv.be});
          check("hold_wdata", mem_wdata, pv.wdata);
        end
        if (mem_gnt) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected", {31'b0, mem_gnt}, 32'd0);
          end else begin
            exp = bus_q.pop_front();
            check("bus_addr", mem_addr, exp.addr);
            check("bus_we", {31'b0, mem_we}, {31'b0, exp.we});
            check("bus_be", {28'b0, mem_be}, {28'b0, exp.be});
            if (exp.we) check("bus_wdata", mem_wdata, exp.wdata);
          end
          if (!mem_we) rd_pending++;
          pv_ok = 1'b0;
          gwait = 0;
        end else begin
          pv = '{mem_addr, mem_we, mem_be, mem_wdata};
          pv_ok = 1'b1;
          gwait++;
        end
      end else begin
        pv_ok = 1'b0;
      end
      if (mem_rvalid && rv_real) rd_pending--;
      @(posedge clk);
      #1;
      case (gnt_mode)
        1:       mem_gnt = 1'b1;
        2:       mem_gnt = 1'b0;
        default: mem_gnt = (mem_req && gwait >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      rv_real = 1'b0;
      if (rd_pending > 0) begin
        if (rv_mode != 2 && (rv_mode == 1 || rwait >= 2 || $urandom_range(0, 1) == 1)) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata_q.size() ? rdata_q.pop_front() : 32'h0;
          rv_real    = 1'b1;
          rwait      = 0;
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          rwait++;
        end
      end else begin
        rwait      = 0;
        mem_rvalid = ($urandom_range(0, 3) == 0);
        mem_rdata  = $urandom;
      end
    end
  end

  // Monitor: write-back and error events against the scoreboard, ready invariant
  initial begin : monitor
    wb_t w;
    forever begin
      @(negedge clk);
      if (wb_we) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", {31'b0, wb_we}, 32'd0);
        end else begin
          w = wb_q.pop_front();
          check("wb_rd", {27'b0, wb_rd}, {27'b0, w.rd});
          check("wb_data", wb_data, w.data);
        end
      end
      if (err) begin
        if (err_q.size() == 0) check("err_unexpected", {31'b0, err}, 32'd0);
        else void'(err_q.pop_front());
      end
      if (mem_req) check("ready_in_req", {31'b0, req_ready}, 32'd0);
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_wb_we"}, {31'b0, wb_we}, 32'd0);
    check({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  // Present one request; returns one cycle after the accepting edge
  task automatic drive_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
    int i;
    for (i = 0; i < 300; i++) begin
      if (req_ready) break;
      @(posedge clk);
      #1;
    end
    if (i == 300) check("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata);
    bit ok;
    logic [3:0] be;
    logic [31:0] wdata, ldata;
    model(we, f3, addr, wd, rdata, ok, be, wdata, ldata);
    if (ok) begin
      bus_q.push_back('{{addr[31:2], 2'b00}, we, be, wdata});
      if (!we) begin
        rdata_q.push_back(rdata);
        if (rd != 5'd0) wb_q.push_back('{rd, ldata});
      end
    end else begin
      err_q.push_back(1);
    end
    drive_req(we, f3, addr, wd, rd);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #2;
      if (req_ready && bus_q.size() == 0 && wb_q.size() == 0 && err_q.size() == 0) return;
    end
    check("idle_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  // Record first cycle (relative to acceptance) of each output event
  task automatic observe(input int cycles, output int f_req, output int f_wb, output int f_rdy,
                         output int f_err, output int n_req, output int n_wb, output int n_rdy);
    f_req = -1; f_wb = -1; f_rdy = -1; f_err = -1; n_req = 0; n_wb = 0; n_rdy = 0;
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clk);
      if (mem_req)   begin n_req++; if (f_req < 0) f_req = n; end
      if (wb_we)     begin n_wb++;  if (f_wb < 0)  f_wb = n;  end
      if (req_ready) begin n_rdy++; if (f_rdy < 0) f_rdy = n; end
      if (err && f_err < 0) f_err = n;
    end
  endtask

  initial begin : stimulus
    int fr, fw, fy, fe, nr, nw, ny;
    logic [4:0] rd;

    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #3 areset = 1'b1;

    // LB, zero-wait bus: latency and sign extension
    gnt_mode = 1; rv_mode = 1;
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 32'h80FF_1234);
    observe(6, fr, fw, fy, fe, nr, nw, ny);
    check("lb_first_req", fr, 1);
    check("lb_first_wb", fw, 3);
    check("lb_wb_cycles", nw, 1);
    check("lb_first_ready", fy, 4);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    wait_idle();

    // LHU upper half, then LW to x0
    issue(1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd12, 32'hBEEF_0000);
    wait_idle();
    check("lhu_wb_data", wb_data, 32'h0000_BEEF);
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd0, 32'h1234_5678);
    observe(6, fr, fw, fy, fe, nr, nw, ny);
    check("lw_x0_no_wb", nw, 0);
    wait_idle();

    // SW store latency
    issue(1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 5'd3, 32'h0);
    observe(3, fr, fw, fy, fe, nr, nw, ny);
    check("sw_first_ready", fy, 2);
    wait_idle();

    // SB with grant held off for three cycles
    gnt_mode = 2;
    issue(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 5'd1, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("sb_hold_req", {31'b0, mem_req}, 32'd1);
      check("sb_hold_ready", {31'b0, req_ready}, 32'd0);
      check("sb_hold_be", {28'b0, mem_be}, 32'h2);
      check("sb_hold_we", {31'b0, mem_we}, 32'd1);
      check("sb_hold_wdata", mem_wdata, 32'hA5A5_A5A5);
      check("sb_hold_addr", mem_addr, 32'h0000_0200);
    end
    gnt_mode = 1;
    wait_idle();

    // Illegal load funct3
    issue(1'b0, 3'b011, 32'h0000_0500, 32'h0, 5'd4, 32'h0);
    observe(4, fr, fw, fy, fe, nr, nw, ny);
    check("illegal_err_cycle", fe, 1);
    check("illegal_no_req", nr, 0);
    check("illegal_ready", ny, 4);
    wait_idle();

    // Reset while waiting for read data
    rv_mode = 2;
    issue(1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd9, 32'h1111_2222);
    for (int n = 0; n < 50 && rd_pending == 0; n++) @(negedge clk);
    check("rst_load_granted", rd_pending, 1);
    @(posedge clk);
    #3 areset = 1'b0;
    @(negedge clk);
    check_reset_values("rst_wait_r");
    #1;
    wb_q.delete(); rdata_q.delete(); rd_pending = 0;
    @(posedge clk);
    #3 areset = 1'b1;
    rv_mode = 0;
    observe(8, fr, fw, fy, fe, nr, nw, ny);
    check("rst_no_wb", nw, 0);
    check("rst_idle_ready", ny, 8);
    rv_mode = 1;
    issue(1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd21, 32'h5A5A_0F0F);
    wait_idle();
    check("rst_next_lw", wb_data, 32'h5A5A_0F0F);

`ifdef LSU_TIMEOUT_EN
    // Grant never arrives: abort after BUS_TIMEOUT REQ cycles
    gnt_mode = 2;
    err_q.push_back(1);
    drive_req(1'b0, 3'b010, 32'h0000_0800, 32'h0, 5'd5);
    observe(6, fr, fw, fy, fe, nr, nw, ny);
    check("to_req_cycles", nr, 4);
    check("to_err_cycle", fe, 5);
    check("to_ready_cycle", fy, 5);
    check("to_no_wb", nw, 0);
    wait_idle();
`endif

    // Randomised traffic with random bus timing
    gnt_mode = 0; rv_mode = 0;
    for (int k = 0; k < 300; k++) begin
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(1'($urandom), 3'($urandom), $urandom, $urandom, rd, $urandom);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    check("bus_q_drained", bus_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
